// File: rtl/disp_scan2_pkg.sv
// Shared types and default sizing for the two-digit display scan sequencer.
// The counter width helper keeps the cycle counter just wide enough for the longer interval.
package disp_scan_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ON    = 2'd1,
    BLANK = 2'd2
  } scan_state_t;

  localparam int DISP_W         = 7;
  localparam int DISP_ON_CYC    = 1000;
  localparam int DISP_BLANK_CYC = 10;

  function automatic int cnt_width(input int on_cyc, input int blank_cyc);
    int m;
    m = (on_cyc > blank_cyc) ? on_cyc : blank_cyc;
    if (m < 1) m = 1;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/disp_scan2_if.sv
// Bundle between the scan sequencer and its surroundings: run level and digit
// patterns in, decoder enable/select, segment bus and frame tick out.
interface disp_scan2_if
  import disp_scan_pkg::*;
#(
  parameter int W = DISP_W
);
  // run is a plain level (no valid/ready pair): sampled every rising edge,
  // high means keep scanning, low abandons the frame on the next edge.
  logic         run;
  logic [W-1:0] D0;
  logic [W-1:0] D1;
  logic         E;
  logic         A0;
  logic [W-1:0] SEG;
  logic         TICK;

  modport master (output run, D0, D1, input E, A0, SEG, TICK);
  modport slave  (input run, D0, D1, output E, A0, SEG, TICK);
endinterface

// File: rtl/disp_scan2.sv
// Two-position display scan sequencer: lights digit 0 then digit 1 on a shared
// segment bus, with optional dark gaps between them and a tick per full frame.
module disp_scan2
  import disp_scan_pkg::*;
#(
  parameter int W         = DISP_W,
  parameter int ON_CYC    = DISP_ON_CYC,
  parameter int BLANK_CYC = DISP_BLANK_CYC
) (
  input  logic          clk,
  input  logic          rst,
  disp_scan2_if.slave   bus,
  output scan_state_t   state_o
);

  localparam int CW = cnt_width(ON_CYC, BLANK_CYC);
  localparam logic [CW-1:0] ON_LAST = CW'(ON_CYC - 1);
  // With no blanking the BLANK state is unreachable, so its terminal count is a don't-care.
  localparam logic [CW-1:0] BL_LAST = (BLANK_CYC > 0) ? CW'(BLANK_CYC - 1) : '0;

  scan_state_t   state_q;
  logic [CW-1:0] cnt_q;
  logic          e_q;
  logic          a0_q;
  logic [W-1:0]  seg_q;
  logic          tick_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      e_q     <= 1'b0;
      a0_q    <= 1'b0;
      seg_q   <= '0;
      tick_q  <= 1'b0;
    end else begin
      tick_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.run) begin
            state_q <= ON;
            cnt_q   <= '0;
            e_q     <= 1'b1;
            a0_q    <= 1'b0;
            seg_q   <= bus.D0;
          end
        end
        ON: begin
          if (!bus.run) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            e_q     <= 1'b0;
            a0_q    <= 1'b0;
            seg_q   <= '0;
          end else if (cnt_q == ON_LAST) begin
            cnt_q  <= '0;
            tick_q <= a0_q;
            if (BLANK_CYC > 0) begin
              state_q <= BLANK;
              e_q     <= 1'b0;
              seg_q   <= '0;
            end else begin
              // Back-to-back digits: E stays high, select and pattern swap together.
              a0_q  <= ~a0_q;
              seg_q <= a0_q ? bus.D0 : bus.D1;
            end
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        BLANK: begin
          if (!bus.run) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            e_q     <= 1'b0;
            a0_q    <= 1'b0;
            seg_q   <= '0;
          end else if (cnt_q == BL_LAST) begin
            state_q <= ON;
            cnt_q   <= '0;
            e_q     <= 1'b1;
            a0_q    <= ~a0_q;
            seg_q   <= a0_q ? bus.D0 : bus.D1;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: begin
          state_q <= IDLE;
          cnt_q   <= '0;
          e_q     <= 1'b0;
          a0_q    <= 1'b0;
          seg_q   <= '0;
        end
      endcase
    end
  end

  assign bus.E    = e_q;
  assign bus.A0   = a0_q;
  assign bus.SEG  = seg_q;
  assign bus.TICK = tick_q;
  assign state_o  = state_q;

endmodule

// File: tb/tb_disp_scan2.sv
// Drives three sequencer configurations (4/2, 3/0, 1/1) with shared stimulus and
// checks each against a frame-position model plus hand-computed waveforms.
module tb_disp_scan2;
  import disp_scan_pkg::*;

  localparam int W = 7;
  localparam int N = 3;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         run = 1'b0;
  logic [W-1:0] d0  = 7'h3F;
  logic [W-1:0] d1  = 7'h06;
  bit           chk_en = 1'b0;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  disp_scan2_if #(.W(W)) if0 ();
  disp_scan2_if #(.W(W)) if1 ();
  disp_scan2_if #(.W(W)) if2 ();

  assign if0.run = run; assign if0.D0 = d0; assign if0.D1 = d1;
  assign if1.run = run; assign if1.D0 = d0; assign if1.D1 = d1;
  assign if2.run = run; assign if2.D0 = d0; assign if2.D1 = d1;

  scan_state_t st0, st1, st2;

  disp_scan2 #(.W(W), .ON_CYC(4), .BLANK_CYC(2)) u0 (.clk(clk), .rst(rst), .bus(if0.slave), .state_o(st0));
  disp_scan2 #(.W(W), .ON_CYC(3), .BLANK_CYC(0)) u1 (.clk(clk), .rst(rst), .bus(if1.slave), .state_o(st1));
  disp_scan2 #(.W(W), .ON_CYC(1), .BLANK_CYC(1)) u2 (.clk(clk), .rst(rst), .bus(if2.slave), .state_o(st2));

  logic         e_o [N];
  logic         a0_o[N];
  logic         tk_o[N];
  logic [W-1:0] sg_o[N];

  assign e_o[0] = if0.E; assign a0_o[0] = if0.A0; assign tk_o[0] = if0.TICK; assign sg_o[0] = if0.SEG;
  assign e_o[1] = if1.E; assign a0_o[1] = if1.A0; assign tk_o[1] = if1.TICK; assign sg_o[1] = if1.SEG;
  assign e_o[2] = if2.E; assign a0_o[2] = if2.A0; assign tk_o[2] = if2.TICK; assign sg_o[2] = if2.SEG;

  function automatic int on_of(input int i);
    case (i)
      0:       return 4;
      1:       return 3;
      default: return 1;
    endcase
  endfunction

  function automatic int bl_of(input int i);
    case (i)
      0:       return 2;
      1:       return 0;
      default: return 1;
    endcase
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: t counts cycles since scanning started; everything follows from frame position.
  bit           m_act[N];
  int           m_t  [N];
  logic [W-1:0] m_lat[N];

  always @(posedge clk) begin
    for (int i = 0; i < N; i++) begin
      int slot;
      slot = on_of(i) + bl_of(i);
      if (rst)              m_act[i] = 1'b0;
      else if (!m_act[i]) begin
        if (run) begin m_act[i] = 1'b1; m_t[i] = 0; end
      end
      else if (run)         m_t[i] = m_t[i] + 1;
      else                  m_act[i] = 1'b0;
      if (m_act[i] && (m_t[i] % slot) == 0)
        m_lat[i] = ((m_t[i] / slot) % 2 == 1) ? d1 : d0;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      for (int i = 0; i < N; i++) begin
        int on, slot, per, t, ph;
        logic xe, xa, xt;
        logic [W-1:0] xs;
        on = on_of(i); slot = on + bl_of(i); per = 2 * slot; t = m_t[i];
        xe = 1'b0; xa = 1'b0; xt = 1'b0; xs = '0;
        if (m_act[i]) begin
          ph = t % per;
          xe = (ph % slot) < on;
          xa = (ph / slot) == 1;
          xs = xe ? m_lat[i] : '0;
          xt = (t >= on + slot) && ((t - on - slot) % per == 0);
        end
        chk($sformatf("m%0d_E", i),    int'(e_o[i]),  int'(xe));
        chk($sformatf("m%0d_A0", i),   int'(a0_o[i]), int'(xa));
        chk($sformatf("m%0d_SEG", i),  int'(sg_o[i]), int'(xs));
        chk($sformatf("m%0d_TICK", i), int'(tk_o[i]), int'(xt));
      end
    end
  end

  task automatic cyc(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  function automatic int seg0_exp(input int k);
    if (k < 4)  return 'h3F;
    if (k < 6)  return 0;
    if (k < 10) return 'h06;
    return 0;
  endfunction

  initial begin
    logic [11:0] e_exp;
    logic [11:0] a_exp;
    e_exp = 12'b1111_0011_1100;
    a_exp = 12'b0000_0011_1111;

    // Reset held three cycles with run high.
    rst = 1'b1; run = 1'b1;
    cyc(1);
    chk_en = 1'b1;
    cyc(2);
    chk("lit_rst_E", int'(if0.E), 0);
    chk("lit_rst_SEG", int'(if0.SEG), 0);
    chk("lit_rst_state", int'(st0 == IDLE), 1);

    // Steady scan, two frames.
    rst = 1'b0;
    for (int k = 0; k < 24; k++) begin
      int j;
      cyc(1);
      j = k % 12;
      chk($sformatf("lit0_E_k%0d", k),    int'(if0.E),    int'(e_exp[11-j]));
      chk($sformatf("lit0_A0_k%0d", k),   int'(if0.A0),   int'(a_exp[11-j]));
      chk($sformatf("lit0_SEG_k%0d", k),  int'(if0.SEG),  seg0_exp(j));
      chk($sformatf("lit0_TICK_k%0d", k), int'(if0.TICK), int'(j == 10));
      chk($sformatf("lit1_E_k%0d", k),    int'(if1.E),    1);
      chk($sformatf("lit1_A0_k%0d", k),   int'(if1.A0),   (k / 3) % 2);
      chk($sformatf("lit1_TICK_k%0d", k), int'(if1.TICK), int'(k >= 6 && k % 6 == 0));
      chk($sformatf("lit2_E_k%0d", k),    int'(if2.E),    int'(k % 2 == 0));
      chk($sformatf("lit2_A0_k%0d", k),   int'(if2.A0),   (k / 2) % 2);
      chk($sformatf("lit2_TICK_k%0d", k), int'(if2.TICK), int'(k % 4 == 3));
    end

    // Pattern change in the middle of digit 0.
    run = 1'b0; cyc(2);
    run = 1'b1; d0 = 7'h3F;
    cyc(2);
    d0 = 7'h5B;
    for (int k = 2; k <= 12; k++) begin
      cyc(1);
      if (k == 2 || k == 3) chk($sformatf("lit_hold_k%0d", k), int'(if0.SEG), 'h3F);
      if (k == 12)          chk("lit_newpat", int'(if0.SEG), 'h5B);
    end

    // Drop run at cycle 1 of digit 1.
    run = 1'b0; cyc(2);
    run = 1'b1; d0 = 7'h3F;
    cyc(8);
    run = 1'b0;
    cyc(1);
    chk("lit_abort_E", int'(if0.E), 0);
    chk("lit_abort_A0", int'(if0.A0), 0);
    chk("lit_abort_TICK", int'(if0.TICK), 0);
    cyc(2);
    run = 1'b1;
    cyc(1);
    chk("lit_restart_E", int'(if0.E), 1);
    chk("lit_restart_A0", int'(if0.A0), 0);
    chk("lit_restart_SEG", int'(if0.SEG), 'h3F);

    // Reset at cycle 1 of digit 1.
    cyc(7);
    rst = 1'b1;
    cyc(1);
    chk("lit_rstmid_E", int'(if0.E), 0);
    chk("lit_rstmid_A0", int'(if0.A0), 0);
    chk("lit_rstmid_TICK", int'(if0.TICK), 0);
    rst = 1'b0;
    cyc(1);
    chk("lit_rstre_E", int'(if0.E), 1);
    chk("lit_rstre_A0", int'(if0.A0), 0);

    d1 = 7'h4F;
    cyc(30);
    @(posedge clk);
    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
